sram_access_arbiter: RTL and testbench
======================================

SRAM_ACCESS_ARBITER -- requirements
Module: sram_access_arbiter

Interface
REQ-001 Parameter AWIDTH, default 19: SRAM word-address width; ring capacity is 2^AWIDTH-1 words.
REQ-002 Parameter WR_BURST, default 8: maximum consecutive write grants per burst, range 1..255.
REQ-003 Parameter RD_BURST, default 8: maximum consecutive read grants per burst, range 1..255.
REQ-004 CLK  input  1  sole clock; every register is clocked on its rising edge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset: assertion takes effect immediately, deassertion is synchronous to CLK.
REQ-006 WR_REQ  input  1  write source holds a valid word.
REQ-007 WR_ACK  output  1  word consumed this cycle; the source pops on this signal.
REQ-008 RD_REQ  input  1  stream sink can accept a read.
REQ-009 RD_COUNT  input  24  read budget in 16-bit words.
REQ-010 RD_COUNT_LOAD  input  1  one-cycle strobe; loads RD_COUNT into the budget.
REQ-011 SRAM_WE  output  1  write strobe to the ZBT controller.
REQ-012 SRAM_RD  output  1  read strobe to the ZBT controller.
REQ-013 ADDR_WR  output  AWIDTH  write pointer.
REQ-014 ADDR_RD  output  AWIDTH  read pointer.
REQ-015 FILL  output  AWIDTH  registered fill level in words.
REQ-016 FULL, EMPTY  output  1 each  ring status flags.
REQ-017 RD_BUDGET  output  24  remaining read budget.

Function
REQ-018 EMPTY is ADDR_WR==ADDR_RD; FULL is ADDR_WR+1==ADDR_RD, with the sum taken modulo 2^AWIDTH.
REQ-019 FILL registers (ADDR_WR-ADDR_RD) mod 2^AWIDTH, so it lags the pointers by 1 cycle.
REQ-020 Eligibility terms: W = WR_REQ & !FULL; R = RD_REQ & !EMPTY & RD_BUDGET!=0.
REQ-021 The state machine has four states: IDLE, WRITE, READ and TURN.
REQ-022 SRAM_WE = (state==WRITE) & W; WR_ACK = SRAM_WE; both are combinational, so there is zero latency from WR_REQ to WR_ACK.
REQ-023 SRAM_RD = (state==READ) & R, combinational.
REQ-024 SRAM_WE and SRAM_RD are never high in the same cycle.
REQ-025 ADDR_WR increments on the cycle after SRAM_WE; ADDR_RD increments on the cycle after SRAM_RD; both wrap from 2^AWIDTH-1 to 0.
REQ-026 RD_BUDGET decrements on SRAM_RD.
REQ-027 RD_COUNT_LOAD loads the budget and takes priority over the decrement: a read in the same cycle still issues but is not subtracted.
REQ-028 Grant from IDLE, with last_dir the direction of the most recent burst:
- W & R: the direction opposite last_dir is granted (round robin).
- Only W: WRITE is granted.
- Only R: READ is granted.
- Neither: the machine stays in IDLE.
REQ-029 On entry to WRITE or READ the burst counter clears; it increments on each grant.
REQ-030 A burst ends when the counter reaches WR_BURST/RD_BURST or when the eligibility term for its direction falls.
REQ-031 When a burst ends, last_dir updates; the next state is the opposite burst if that direction is eligible, otherwise IDLE.
REQ-032 A direction held low by FULL, EMPTY or a zero budget produces no strobe; the burst ends on the next cycle.
REQ-033 RD_BUDGET==0 blocks reads only; writes continue until FULL.

Reset
REQ-034 While RESET_N is low:
- ADDR_WR, ADDR_RD, FILL, RD_BUDGET and the burst counter are 0.
- state is IDLE and last_dir is READ, so writes win the first tie.
- SRAM_WE, SRAM_RD and WR_ACK are 0; EMPTY is 1 and FULL is 0.
REQ-035 Reset asserted mid-burst aborts the burst immediately and discards all ring contents.

Configuration
REQ-036 Macro SRAM_ARB_TURNAROUND_EN controls the bus-turnaround cycle.
- Defined: every grant whose direction differs from last_dir first enters TURN for exactly 1 cycle with no strobes, then enters the granted burst.
- Undefined: the TURN state is never entered; direction changes take 0 cycles.

Verification
REQ-037 Reset, then WR_REQ=1 held for 20 cycles with RD_REQ=0 -> 20 WR_ACK pulses, ADDR_WR=20, FILL=20 one cycle later.
REQ-038 FILL=10, RD_COUNT=4 loaded, RD_REQ=1 held -> exactly 4 SRAM_RD pulses, ADDR_RD=4, RD_BUDGET=0, FILL=6.
REQ-039 AWIDTH=4 with WR_REQ held -> 15 writes, then FULL=1 and WR_ACK stays 0; one read then allows exactly 1 further write.
REQ-040 WR_REQ=RD_REQ=1 continuous, budget 100, FILL=50 -> strobes alternate 8 writes, 8 reads; with SRAM_ARB_TURNAROUND_EN one idle cycle is inserted at each switch.
REQ-041 RESET_N pulsed low in the 3rd cycle of a write burst -> pointers are 0 asynchronously, strobes drop in the same cycle, EMPTY=1.
REQ-042 RD_COUNT_LOAD with RD_COUNT=5 coincident with a read while RD_BUDGET=2 -> RD_BUDGET=5 next cycle, ADDR_RD advances by 1.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// Write/read arbiter for a ring buffer held in a single-port ZBT SRAM.
// Optional bus-turnaround cycle on direction changes: define SRAM_ARB_TURNAROUND_EN.
module sram_access_arbiter #(
    parameter int AWIDTH   = 19,
    parameter int WR_BURST = 8,
    parameter int RD_BURST = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              WR_REQ,
    output logic              WR_ACK,
    input  logic              RD_REQ,
    input  logic [23:0]       RD_COUNT,
    input  logic              RD_COUNT_LOAD,
    output logic              SRAM_WE,
    output logic              SRAM_RD,
    output logic [AWIDTH-1:0] ADDR_WR,
    output logic [AWIDTH-1:0] ADDR_RD,
    output logic [AWIDTH-1:0] FILL,
    output logic              FULL,
    output logic              EMPTY,
    output logic [23:0]       RD_BUDGET
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } dir_t;

`ifdef SRAM_ARB_TURNAROUND_EN
    localparam logic TURN_EN = 1'b1;
`else
    localparam logic TURN_EN = 1'b0;
`endif

    localparam logic [8:0] WR_BURST_L = 9'(WR_BURST);
    localparam logic [8:0] RD_BURST_L = 9'(RD_BURST);

    state_t             state_q, state_d;
    dir_t               last_dir_q, last_dir_d;
    dir_t               turn_dir_q, turn_dir_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;
    logic [AWIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AWIDTH-1:0]  fill_q, fill_d;
    logic [23:0]        budget_q, budget_d;

    logic [AWIDTH-1:0]  wr_ptr_inc_s;
    logic [AWIDTH-1:0]  rd_ptr_inc_s;
    logic [8:0]         burst_cnt_inc_s;
    logic               full_s, empty_s;
    logic               w_elig_s, r_elig_s;
    logic               we_s, rd_s;
    logic               enter_s;
    dir_t               enter_dir_s;

    // Ring status and eligibility, all derived from registered pointers and budget.
    always_comb begin
        wr_ptr_inc_s    = wr_ptr_q + {{(AWIDTH-1){1'b0}}, 1'b1};
        rd_ptr_inc_s    = rd_ptr_q + {{(AWIDTH-1){1'b0}}, 1'b1};
        burst_cnt_inc_s = {1'b0, burst_cnt_q} + 9'd1;
        empty_s         = (wr_ptr_q == rd_ptr_q);
        full_s          = (wr_ptr_inc_s == rd_ptr_q);
        w_elig_s        = WR_REQ & ~full_s;
        r_elig_s        = RD_REQ & ~empty_s & (budget_q != 24'd0);
        we_s            = (state_q == ST_WRITE) & w_elig_s;
        rd_s            = (state_q == ST_READ) & r_elig_s;
    end

    // Burst sequencing: grant selection, burst termination and optional turnaround.
    always_comb begin
        state_d     = state_q;
        last_dir_d  = last_dir_q;
        turn_dir_d  = turn_dir_q;
        burst_cnt_d = burst_cnt_q;
        enter_s     = 1'b0;
        enter_dir_s = DIR_WRITE;
        case (state_q)
            ST_IDLE: begin
                if (w_elig_s && r_elig_s) begin
                    enter_s     = 1'b1;
                    enter_dir_s = (last_dir_q == DIR_READ) ? DIR_WRITE : DIR_READ;
                end else if (w_elig_s) begin
                    enter_s     = 1'b1;
                    enter_dir_s = DIR_WRITE;
                end else if (r_elig_s) begin
                    enter_s     = 1'b1;
                    enter_dir_s = DIR_READ;
                end else begin
                    enter_s     = 1'b0;
                end
            end
            ST_WRITE: begin
                if (w_elig_s && (burst_cnt_inc_s < WR_BURST_L)) begin
                    burst_cnt_d = burst_cnt_inc_s[7:0];
                end else begin
                    last_dir_d = DIR_WRITE;
                    if (r_elig_s) begin
                        enter_s     = 1'b1;
                        enter_dir_s = DIR_READ;
                    end else begin
                        state_d     = ST_IDLE;
                        burst_cnt_d = 8'd0;
                    end
                end
            end
            ST_READ: begin
                if (r_elig_s && (burst_cnt_inc_s < RD_BURST_L)) begin
                    burst_cnt_d = burst_cnt_inc_s[7:0];
                end else begin
                    last_dir_d = DIR_READ;
                    if (w_elig_s) begin
                        enter_s     = 1'b1;
                        enter_dir_s = DIR_WRITE;
                    end else begin
                        state_d     = ST_IDLE;
                        burst_cnt_d = 8'd0;
                    end
                end
            end
            ST_TURN: begin
                // The dead cycle is over; go straight into the burst chosen before it.
                burst_cnt_d = 8'd0;
                state_d     = (turn_dir_q == DIR_WRITE) ? ST_WRITE : ST_READ;
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = 8'd0;
            end
        endcase

        if (enter_s) begin
            burst_cnt_d = 8'd0;
            if (TURN_EN && (enter_dir_s != last_dir_d)) begin
                state_d    = ST_TURN;
                turn_dir_d = enter_dir_s;
            end else if (enter_dir_s == DIR_WRITE) begin
                state_d    = ST_WRITE;
            end else begin
                state_d    = ST_READ;
            end
        end else begin
            turn_dir_d = turn_dir_q;
        end
    end

    // Pointer, fill and budget next-state; a budget load wins over the read decrement.
    always_comb begin
        wr_ptr_d = we_s ? wr_ptr_inc_s : wr_ptr_q;
        rd_ptr_d = rd_s ? rd_ptr_inc_s : rd_ptr_q;
        fill_d   = wr_ptr_q - rd_ptr_q;
        if (RD_COUNT_LOAD) begin
            budget_d = RD_COUNT;
        end else if (rd_s) begin
            budget_d = budget_q - 24'd1;
        end else begin
            budget_d = budget_q;
        end
    end

    // State registers with asynchronous reset; last_dir starts at READ so writes win the first tie.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            last_dir_q  <= DIR_READ;
            turn_dir_q  <= DIR_WRITE;
            burst_cnt_q <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            budget_q    <= 24'd0;
        end else begin
            state_q     <= state_d;
            last_dir_q  <= last_dir_d;
            turn_dir_q  <= turn_dir_d;
            burst_cnt_q <= burst_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            budget_q    <= budget_d;
        end
    end

    assign SRAM_WE   = we_s;
    assign WR_ACK    = we_s;
    assign SRAM_RD   = rd_s;
    assign ADDR_WR   = wr_ptr_q;
    assign ADDR_RD   = rd_ptr_q;
    assign FILL      = fill_q;
    assign FULL      = full_s;
    assign EMPTY     = empty_s;
    assign RD_BUDGET = budget_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: a default-width instance plus an AWIDTH=4 instance for full/wrap.
module tb_sram_access_arbiter;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_n;
    logic        wr_req, rd_req, rd_count_load;
    logic [23:0] rd_count;
    logic        wr_ack, sram_we, sram_rd, full, empty;
    logic [18:0] addr_wr, addr_rd, fill;
    logic [23:0] rd_budget;

    logic        s_wr_req, s_rd_req, s_rd_count_load;
    logic [23:0] s_rd_count;
    logic        s_wr_ack, s_sram_we, s_sram_rd, s_full, s_empty;
    logic [3:0]  s_addr_wr, s_addr_rd, s_fill;
    logic [23:0] s_rd_budget;

    int checks = 0;
    int errors = 0;
    int model_wr = 0;
    int exp_q[$];

    sram_access_arbiter dut (
        .CLK(CLK), .RESET_N(rst_n), .WR_REQ(wr_req), .WR_ACK(wr_ack),
        .RD_REQ(rd_req), .RD_COUNT(rd_count), .RD_COUNT_LOAD(rd_count_load),
        .SRAM_WE(sram_we), .SRAM_RD(sram_rd), .ADDR_WR(addr_wr), .ADDR_RD(addr_rd),
        .FILL(fill), .FULL(full), .EMPTY(empty), .RD_BUDGET(rd_budget)
    );

    sram_access_arbiter #(.AWIDTH(4)) dut_small (
        .CLK(CLK), .RESET_N(rst_n), .WR_REQ(s_wr_req), .WR_ACK(s_wr_ack),
        .RD_REQ(s_rd_req), .RD_COUNT(s_rd_count), .RD_COUNT_LOAD(s_rd_count_load),
        .SRAM_WE(s_sram_we), .SRAM_RD(s_sram_rd), .ADDR_WR(s_addr_wr), .ADDR_RD(s_addr_rd),
        .FILL(s_fill), .FULL(s_full), .EMPTY(s_empty), .RD_BUDGET(s_rd_budget)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge CLK);
        rst_n = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; rd_count = 24'd0; rd_count_load = 1'b0;
        s_wr_req = 1'b0; s_rd_req = 1'b0; s_rd_count = 24'd0; s_rd_count_load = 1'b0;
        model_wr = 0;
        exp_q.delete();
        @(negedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    task automatic write_n(input int n);
        int acks;
        acks = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(model_wr + i);
        for (int c = 0; c < 20 * n + 20; c++) begin
            @(negedge CLK);
            wr_req = 1'b1;
            #1;
            if (wr_ack) begin
                int e;
                e = exp_q.pop_front();
                checks++;
                if (addr_wr !== 19'(e) || sram_we !== 1'b1 || sram_rd !== 1'b0) begin
                    errors++;
                    $display("FAIL write_addr: got addr=%0d we=%0b rd=%0b expected addr=%0d we=1 rd=0",
                             addr_wr, sram_we, sram_rd, e);
                end
                acks++;
                if (acks == n) break;
            end
        end
        checks++;
        if (acks != n) begin
            errors++;
            $display("FAIL write_count: got %0d expected %0d", acks, n);
        end
        exp_q.delete();
        model_wr += n;
        @(negedge CLK);
        wr_req = 1'b0;
    endtask

    task automatic load_budget(input int b);
        @(negedge CLK);
        rd_count = 24'(b);
        rd_count_load = 1'b1;
        @(negedge CLK);
        rd_count_load = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        rst_n = 1'b0;
        wr_req = 1'b1; rd_req = 1'b1;
        #1;
        checks++;
        if (addr_wr !== 19'd0 || addr_rd !== 19'd0 || fill !== 19'd0 || rd_budget !== 24'd0) begin
            errors++;
            $display("FAIL reset_regs: got wr=%0d rd=%0d fill=%0d bud=%0d expected all 0",
                     addr_wr, addr_rd, fill, rd_budget);
        end
        checks++;
        if (sram_we !== 1'b0 || sram_rd !== 1'b0 || wr_ack !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got we=%0b rd=%0b ack=%0b empty=%0b full=%0b expected 0 0 0 1 0",
                     sram_we, sram_rd, wr_ack, empty, full);
        end
        do_reset();
    endtask

    task automatic test_write_fill();
        do_reset();
        write_n(20);
        #1;
        checks++;
        if (wr_ack !== 1'b0 || addr_wr !== 19'd20 || fill !== 19'd19) begin
            errors++;
            $display("FAIL write_fill_lag: got ack=%0b addr=%0d fill=%0d expected 0 20 19", wr_ack, addr_wr, fill);
        end
        @(negedge CLK);
        #1;
        checks++;
        if (fill !== 19'd20 || empty !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL write_fill: got fill=%0d empty=%0b full=%0b expected 20 0 0", fill, empty, full);
        end
    endtask

    task automatic test_read_budget();
        int reads;
        reads = 0;
        do_reset();
        write_n(10);
        load_budget(4);
        #1;
        checks++;
        if (rd_budget !== 24'd4 || fill !== 19'd10) begin
            errors++;
            $display("FAIL budget_load: got bud=%0d fill=%0d expected 4 10", rd_budget, fill);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            rd_req = 1'b1;
            #1;
            if (sram_rd) begin
                int e;
                reads++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                checks++;
                if (addr_rd !== 19'(e) || sram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL read_addr: got addr=%0d we=%0b expected addr=%0d we=0", addr_rd, sram_we, e);
                end
            end
        end
        rd_req = 1'b0;
        checks++;
        if (reads != 4 || addr_rd !== 19'd4 || rd_budget !== 24'd0 || fill !== 19'd6) begin
            errors++;
            $display("FAIL read_budget: got reads=%0d addr=%0d bud=%0d fill=%0d expected 4 4 0 6",
                     reads, addr_rd, rd_budget, fill);
        end
    endtask

    task automatic test_alternate();
        int exp_w, exp_r;
        exp_w = 0; exp_r = 0;
        do_reset();
        write_n(50);
        load_budget(100);
        // Expected strobe code per cycle: 0 none, 1 write, 2 read; first cycle is the IDLE grant.
        exp_q.push_back(0);
        for (int j = 0; j < 39; j++) begin
            int code;
`ifdef SRAM_ARB_TURNAROUND_EN
            if ((j % 9) == 0) code = 0;
            else code = (((j / 9) % 2) == 0) ? 2 : 1;
`else
            code = (((j / 8) % 2) == 0) ? 2 : 1;
`endif
            if (code == 1) exp_w++;
            if (code == 2) exp_r++;
            exp_q.push_back(code);
        end
        for (int c = 0; c < 40; c++) begin
            int e;
            @(negedge CLK);
            wr_req = 1'b1; rd_req = 1'b1;
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({sram_rd, sram_we} !== 2'(e)) begin
                errors++;
                $display("FAIL alternate_cycle%0d: got rd/we=%0b%0b expected code %0d", c, sram_rd, sram_we, e);
            end
        end
        @(negedge CLK);
        wr_req = 1'b0; rd_req = 1'b0;
        #1;
        checks++;
        if (addr_wr !== 19'(50 + exp_w) || addr_rd !== 19'(exp_r) || rd_budget !== 24'(100 - exp_r)) begin
            errors++;
            $display("FAIL alternate_totals: got wr=%0d rd=%0d bud=%0d expected %0d %0d %0d",
                     addr_wr, addr_rd, rd_budget, 50 + exp_w, exp_r, 100 - exp_r);
        end
    endtask

    task automatic test_reset_mid_burst();
        int acks;
        acks = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            wr_req = 1'b1;
            #1;
            if (wr_ack) acks++;
            if (acks == 3) break;
        end
        checks++;
        if (acks != 3 || addr_wr !== 19'd2) begin
            errors++;
            $display("FAIL pre_reset: got acks=%0d addr=%0d expected 3 2", acks, addr_wr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (addr_wr !== 19'd0 || addr_rd !== 19'd0 || sram_we !== 1'b0 || wr_ack !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got wr=%0d rd=%0d we=%0b ack=%0b empty=%0b expected 0 0 0 0 1",
                     addr_wr, addr_rd, sram_we, wr_ack, empty);
        end
        wr_req = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    task automatic test_load_coincident();
        logic hit;
        hit = 1'b0;
        do_reset();
        write_n(5);
        load_budget(2);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            rd_req = 1'b1;
            #1;
            if (sram_rd) begin
                hit = 1'b1;
                checks++;
                if (rd_budget !== 24'd2 || addr_rd !== 19'd0) begin
                    errors++;
                    $display("FAIL coincide_pre: got bud=%0d addr=%0d expected 2 0", rd_budget, addr_rd);
                end
                rd_count = 24'd5;
                rd_count_load = 1'b1;
                break;
            end
        end
        @(negedge CLK);
        rd_count_load = 1'b0;
        rd_req = 1'b0;
        #1;
        checks++;
        if (!hit || rd_budget !== 24'd5 || addr_rd !== 19'd1) begin
            errors++;
            $display("FAIL coincide_load: got hit=%0b bud=%0d addr=%0d expected 1 5 1", hit, rd_budget, addr_rd);
        end
    endtask

    task automatic test_small_full();
        int acks, reads, writes;
        acks = 0; reads = 0; writes = 0;
        do_reset();
        @(negedge CLK);
        s_rd_count = 24'd1;
        s_rd_count_load = 1'b1;
        @(negedge CLK);
        s_rd_count_load = 1'b0;
        for (int i = 0; i < 15; i++) exp_q.push_back(i);
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            s_wr_req = 1'b1;
            #1;
            if (s_wr_ack) begin
                int e;
                acks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                checks++;
                if (s_addr_wr !== 4'(e)) begin
                    errors++;
                    $display("FAIL small_addr: got %0d expected %0d", s_addr_wr, e);
                end
            end
        end
        checks++;
        if (acks != 15 || s_full !== 1'b1 || s_wr_ack !== 1'b0 || s_fill !== 4'd15) begin
            errors++;
            $display("FAIL small_full: got acks=%0d full=%0b ack=%0b fill=%0d expected 15 1 0 15",
                     acks, s_full, s_wr_ack, s_fill);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            s_rd_req = 1'b1;
            #1;
            if (s_sram_rd) reads++;
            if (s_sram_we) writes++;
            if (s_sram_rd && s_sram_we) begin
                checks++;
                errors++;
                $display("FAIL small_exclusive: got we=1 rd=1 expected at most one");
            end
        end
        s_rd_req = 1'b0; s_wr_req = 1'b0;
        checks++;
        if (reads != 1 || writes != 1 || s_full !== 1'b1 || s_addr_wr !== 4'd0 || s_addr_rd !== 4'd1) begin
            errors++;
            $display("FAIL small_refill: got reads=%0d writes=%0d full=%0b wr=%0d rd=%0d expected 1 1 1 0 1",
                     reads, writes, s_full, s_addr_wr, s_addr_rd);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; rd_count = 24'd0; rd_count_load = 1'b0;
        s_wr_req = 1'b0; s_rd_req = 1'b0; s_rd_count = 24'd0; s_rd_count_load = 1'b0;
        test_reset();
        test_write_fill();
        test_read_budget();
        test_alternate();
        test_reset_mid_burst();
        test_load_coincident();
        test_small_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
